// File: rtl/output_drain_streamer.sv
// output_drain_streamer: reads the Output SRAM from address 0 to Output_Nums-1 through a small FIFO
// onto a valid/ready stream with index/last markers. Define DRAIN_CLEAR_EN to zero each word as it is captured.
module output_drain_streamer #(
  parameter int Output_Addr_Width = 3,
  parameter int Output_Nums       = 8,
  parameter int Data_Width        = 16,
  parameter int FIFO_Depth        = 2
) (
  input  logic                         clk,
  input  logic                         Reset_n,
  input  logic                         Drain_Start,
  output logic                         Drain_Busy,
  output logic                         Drain_Done,
  output logic                         Mem_Out_En_CS,
  output logic                         Mem_Out_En_R,
  output logic [Output_Addr_Width-1:0] Mem_Output_Addr_Read,
`ifdef DRAIN_CLEAR_EN
  output logic                         Mem_Out_En_W,
  output logic [Output_Addr_Width-1:0] Mem_Output_Addr_Write,
  output logic [Data_Width-1:0]        Mem_Output_Data_Write,
`endif
  input  logic [Data_Width-1:0]        Mem_Output_Data_Read,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [Data_Width-1:0]        Out_Data,
  output logic [Output_Addr_Width-1:0] Out_Index,
  output logic                         Out_Last
);

  localparam int PW = (FIFO_Depth > 1) ? $clog2(FIFO_Depth) : 1;
  localparam int CW = PW + 1;
  localparam logic [Output_Addr_Width-1:0] LAST_ADDR = Output_Addr_Width'(Output_Nums - 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_Depth);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t                       state, state_next;
  logic [Output_Addr_Width-1:0] issue_addr;
  logic [Output_Addr_Width-1:0] inflight_addr;
  logic                         inflight;
  logic [CW-1:0]                fifo_count;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [Data_Width-1:0]        fifo_data  [FIFO_Depth];
  logic [Output_Addr_Width-1:0] fifo_index [FIFO_Depth];

  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;

  // The word read last cycle lands in the FIFO now, whether or not the sink is ready.
  assign push      = inflight;
  assign Out_Valid = (fifo_count != '0);
  assign pop       = Out_Valid & Out_Ready;
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};

  // Buffered plus in-flight words never exceed the FIFO; a same-cycle pop frees one slot,
  // which is what sustains one word per cycle with Out_Ready held high.
  assign issue = (state == READ) && (occupancy < (DEPTH + {{CW{1'b0}}, pop}));

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (Drain_Start) state_next = READ;
      READ:    if (issue && (issue_addr == LAST_ADDR)) state_next = FLUSH;
      FLUSH:   if (!inflight && ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)))
                 state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset_n) begin
      state         <= IDLE;
      issue_addr    <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      fifo_count    <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (state == IDLE && Drain_Start)
        issue_addr <= '0;
      else if (issue && (issue_addr != LAST_ADDR))
        issue_addr <= issue_addr + Output_Addr_Width'(1);
      if (issue) inflight_addr <= issue_addr;
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    // NOTE: the storage is only a few registers, so it is reset to keep the stream outputs 0 out of reset.
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_Depth; i++) begin
        fifo_data[i]  <= '0;
        fifo_index[i] <= '0;
      end
    end else if (push) begin
      fifo_data[wr_ptr]  <= Mem_Output_Data_Read;
      fifo_index[wr_ptr] <= inflight_addr;
    end
  end

  assign Out_Data             = fifo_data[rd_ptr];
  assign Out_Index            = fifo_index[rd_ptr];
  assign Out_Last             = Out_Valid && (Out_Index == LAST_ADDR);
  assign Drain_Busy           = (state == READ) || (state == FLUSH);
  assign Drain_Done           = (state == DONE);
  assign Mem_Out_En_R         = issue;
  assign Mem_Output_Addr_Read = issue ? issue_addr : '0;

`ifdef DRAIN_CLEAR_EN
  // Clear-after-read: the captured location is zeroed in the same cycle it enters the FIFO.
  assign Mem_Out_En_W          = inflight;
  assign Mem_Output_Addr_Write = inflight ? inflight_addr : '0;
  assign Mem_Output_Data_Write = '0;
  assign Mem_Out_En_CS         = issue | inflight;
`else
  assign Mem_Out_En_CS         = issue;
`endif

endmodule

// File: tb/tb_output_drain_streamer.sv
// Scoreboard bench for output_drain_streamer: stimulus queues expected words, a negedge monitor checks
// every handshake, SRAM read ordering, buffer occupancy and the Done pulse.
module tb_output_drain_streamer;
  localparam int AW    = 3;
  localparam int NUMS  = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] index;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Drain_Start = 1'b0;
  logic          Out_Ready = 1'b0;
  logic          Drain_Busy, Drain_Done, Mem_Out_En_CS, Mem_Out_En_R;
  logic [AW-1:0] Mem_Output_Addr_Read, Out_Index;
  logic [DW-1:0] Mem_Output_Data_Read, Out_Data;
  logic          Out_Valid, Out_Last;
`ifdef DRAIN_CLEAR_EN
  logic          Mem_Out_En_W;
  logic [AW-1:0] Mem_Output_Addr_Write;
  logic [DW-1:0] Mem_Output_Data_Write;
`endif

  int checks = 0;
  int errors = 0;

  word_t         exp_q[$];
  logic [DW-1:0] mem [NUMS];
  int            cyc = 0;
  int            reads = 0;
  int            pops = 0;
  int            exp_rd_addr = 0;
  int            done_count = 0;
  int            first_hs_cyc = 0;
  int            last_hs_cyc = 0;
  logic          done_due = 1'b0;
  logic          stalled = 1'b0;
  logic [DW+AW-1:0] stall_word = '0;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;

  output_drain_streamer #(
    .Output_Addr_Width(AW), .Output_Nums(NUMS), .Data_Width(DW), .FIFO_Depth(DEPTH)
  ) dut (
    .clk(clk),
    .Reset_n(Reset_n),
    .Drain_Start(Drain_Start),
    .Drain_Busy(Drain_Busy),
    .Drain_Done(Drain_Done),
    .Mem_Out_En_CS(Mem_Out_En_CS),
    .Mem_Out_En_R(Mem_Out_En_R),
    .Mem_Output_Addr_Read(Mem_Output_Addr_Read),
`ifdef DRAIN_CLEAR_EN
    .Mem_Out_En_W(Mem_Out_En_W),
    .Mem_Output_Addr_Write(Mem_Output_Addr_Write),
    .Mem_Output_Data_Write(Mem_Output_Data_Write),
`endif
    .Mem_Output_Data_Read(Mem_Output_Data_Read),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Out_Data(Out_Data),
    .Out_Index(Out_Index),
    .Out_Last(Out_Last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output SRAM model: registered read, data valid one cycle after En_R.
  always @(posedge clk) begin
    if (Mem_Out_En_R) Mem_Output_Data_Read <= mem[Mem_Output_Addr_Read];
`ifdef DRAIN_CLEAR_EN
    if (Mem_Out_En_W) mem[Mem_Output_Addr_Write] = Mem_Output_Data_Write;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are sampled at the falling edge, half a cycle from any input change.
  always @(negedge clk) begin
    if (Reset_n) begin
      if (done_due || Drain_Done) check("done_pulse", Drain_Done, done_due);
      done_due = 1'b0;
      if (Drain_Done) begin
        done_count++;
        check("busy_low_at_done", Drain_Busy, 0);
      end

      if (Mem_Out_En_R) begin
        check("read_addr", Mem_Output_Addr_Read, exp_rd_addr);
        check("read_cs", Mem_Out_En_CS, 1);
        check("occupancy_le_depth",
              ((reads + 1 - pops - ((Out_Valid && Out_Ready) ? 1 : 0)) <= DEPTH) ? 1 : 0, 1);
        exp_rd_addr++;
        reads++;
      end

`ifdef DRAIN_CLEAR_EN
      if (Mem_Out_En_W) begin
        check("write_follows_read", prev_rd, 1);
        check("write_addr_trails", Mem_Output_Addr_Write, prev_rd_addr);
        check("write_data_zero", Mem_Output_Data_Write, 0);
        check("write_cs", Mem_Out_En_CS, 1);
      end
`endif
      prev_rd      = Mem_Out_En_R;
      prev_rd_addr = Mem_Output_Addr_Read;

      if (Out_Valid) begin
        if (stalled) check("stall_stable", {Out_Data, Out_Index}, stall_word);
        if (Out_Ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_word: got index %0d data 0x%0h, expected no word", Out_Index, Out_Data);
          end else begin
            word_t w;
            w = exp_q.pop_front();
            check("out_data", Out_Data, w.data);
            check("out_index", Out_Index, w.index);
            check("out_last", Out_Last, w.last);
            if (pops == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            pops++;
            if (w.last) done_due = 1'b1;
          end
        end else begin
          stalled    = 1'b1;
          stall_word = {Out_Data, Out_Index};
        end
      end
    end else begin
      stalled  = 1'b0;
      done_due = 1'b0;
      prev_rd  = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < NUMS; i++) mem[i] = DW'(16'h0010 + i);
  endtask

  task automatic expect_all();
    word_t w;
    exp_q.delete();
    for (int i = 0; i < NUMS; i++) begin
      w.data  = DW'(16'h0010 + i);
      w.index = AW'(i);
      w.last  = (i == NUMS - 1);
      exp_q.push_back(w);
    end
    exp_rd_addr = 0;
    reads       = 0;
    pops        = 0;
  endtask

  task automatic pulse_start();
    Drain_Start = 1'b1;
    tick(1);
    Drain_Start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input logic [3:0] pat, input int budget);
    int d0;
    int k;
    d0 = done_count;
    k  = 0;
    while (done_count == d0 && k < budget) begin
      Out_Ready = pat[k % 4];
      tick(1);
      k++;
    end
    if (done_count == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no Drain_Done within %0d cycles", name, budget);
    end
    Out_Ready = 1'b1;
    tick(2);
    check({name, "_done_count"}, done_count - d0, 1);
    check({name, "_words"}, pops, NUMS);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, Drain_Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    preload();

    // Reset state.
    #1;
    check("rst_valid", Out_Valid, 0);
    check("rst_busy", Drain_Busy, 0);
    check("rst_done", Drain_Done, 0);
    check("rst_en_r", Mem_Out_En_R, 0);
    check("rst_cs", Mem_Out_En_CS, 0);
    check("rst_data", Out_Data, 0);
    check("rst_index", Out_Index, 0);
    check("rst_last", Out_Last, 0);
    tick(2);
    Reset_n = 1'b1;
    tick(2);

    // Full throughput with Out_Ready held high.
    expect_all();
    Out_Ready = 1'b1;
    pulse_start();
    check("t1_busy", Drain_Busy, 1);
    tick(1);
    check("t1_valid_not_yet", Out_Valid, 0);
    tick(1);
    check("t1_first_valid", Out_Valid, 1);
    check("t1_first_data", Out_Data, 16'h0010);
    check("t1_busy_mid", Drain_Busy, 1);
    run_until_done("t1", 4'b1111, 40);
    check("t1_back_to_back", last_hs_cyc - first_hs_cyc, NUMS - 1);
`ifdef DRAIN_CLEAR_EN
    for (int i = 0; i < NUMS; i++) check("clear_mem", mem[i], 0);
`endif

    // Ready toggling 1,0,0,1.
    preload();
    expect_all();
    pulse_start();
    run_until_done("t2", 4'b1001, 80);

    // Long stall: only DEPTH reads may issue.
    preload();
    expect_all();
    Out_Ready = 1'b0;
    pulse_start();
    tick(20);
    check("t3_reads_stalled", reads, DEPTH);
    check("t3_valid", Out_Valid, 1);
    check("t3_head", Out_Data, 16'h0010);
    run_until_done("t3", 4'b1111, 40);

    // Reset at the 4th handshake.
    preload();
    expect_all();
    Out_Ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 40 && pops < 3; k++) tick(1);
    check("t4_pops_before_reset", pops, 3);
    d0 = done_count;
    #1;
    Reset_n = 1'b0;
    #1;
    check("t4_rst_valid", Out_Valid, 0);
    check("t4_rst_busy", Drain_Busy, 0);
    check("t4_rst_en_r", Mem_Out_En_R, 0);
    check("t4_rst_cs", Mem_Out_En_CS, 0);
    check("t4_rst_data", Out_Data, 0);
    check("t4_rst_index", Out_Index, 0);
    check("t4_rst_last", Out_Last, 0);
    exp_q.delete();
    tick(2);
    Reset_n = 1'b1;
    tick(5);
    check("t4_no_done", done_count - d0, 0);
    preload();
    expect_all();
    pulse_start();
    run_until_done("t4_restart", 4'b1111, 40);

    // Start re-pulsed mid-drain is ignored.
    preload();
    expect_all();
    pulse_start();
    tick(3);
    pulse_start();
    run_until_done("t5", 4'b1111, 40);
    tick(5);
    check("t5_reads", reads, NUMS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
